reg_scoreboard: RTL and testbench

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/mycpu_pkg.sv | 53 +++++
 rtl/sb_entry.sv | 70 +++++++
 rtl/reg_scoreboard.sv | 72 +++++++
 tb/tb_reg_scoreboard.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// Shared CPU-wide types: pipeline stage tags, forwarding-select encoding and
// the register scoreboard entry record.
package mycpu_pkg;

    localparam int REG_W    = 5;
    localparam int NUM_REGS = 32;
    localparam int CNT_W    = 2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Stage values double as the forwarding-select code, so the mapping is direct.
    typedef enum logic [1:0] {
        STG_IDLE = 2'b00,
        STG_EXE  = 2'b01,
        STG_MEM  = 2'b10,
        STG_WB   = 2'b11
    } stage_e;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_EXE = 2'b01;
    localparam fwd_sel_t FWD_MEM = 2'b10;
    localparam fwd_sel_t FWD_WB  = 2'b11;

    typedef struct packed {
        logic [CNT_W-1:0] count;
        stage_e           stage;
        logic             is_load;
    } sb_state_t;

    localparam sb_state_t SB_IDLE = '{count: '0, stage: STG_IDLE, is_load: 1'b0};

    function automatic fwd_sel_t fwd_of(input sb_state_t e);
        fwd_sel_t sel;
        sel = FWD_RF;
        if (e.count != '0) begin
            case (e.stage)
                STG_EXE: sel = FWD_EXE;
                STG_MEM: sel = FWD_MEM;
                STG_WB:  sel = FWD_WB;
                default: sel = FWD_RF;
            endcase
        end
        return sel;
    endfunction

    // A load still in EXE has no data yet; anything later can be forwarded.
    function automatic logic load_hazard(input sb_state_t e);
        return (e.count != '0) && (e.stage == STG_EXE) && e.is_load;
    endfunction

endpackage

// File: rtl/sb_entry.sv
// One scoreboard slot: in-flight writer count, youngest-writer stage and
// youngest-writer-is-load bit for a single architectural register.
module sb_entry
    import mycpu_pkg::*;
(
    input  logic      clk,
    input  logic      resetn,
    input  logic      issue_hit,
    input  logic      issue_load,
    input  logic      retire_hit,
    input  logic      es_fire,
    input  logic      ms_fire,
    input  logic      flush,
    output sb_state_t state,
    output logic      overflow
);

    sb_state_t state_q;
    sb_state_t state_d;
    stage_e    stage_adv;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        stage_adv = state_q.stage;
        // Advance decisions look only at the current stage, so a simultaneous
        // es_fire/ms_fire moves an EXE writer to MEM, never straight to WB.
        case (state_q.stage)
            STG_EXE: if (es_fire) stage_adv = STG_MEM;
            STG_MEM: if (ms_fire) stage_adv = STG_WB;
            default: stage_adv = state_q.stage;
        endcase

        state_d       = state_q;
        state_d.stage = stage_adv;
        overflow      = 1'b0;

        if (flush) begin
            state_d = SB_IDLE;
        end else if (issue_hit && retire_hit) begin
            state_d.stage   = STG_EXE;
            state_d.is_load = issue_load;
        end else if (issue_hit) begin
            if (state_q.count == CNT_MAX) begin
                overflow = 1'b1;
            end else begin
                state_d.count = state_q.count + 1'b1;
            end
            state_d.stage   = STG_EXE;
            state_d.is_load = issue_load;
        end else if (retire_hit) begin
            if (state_q.count <= CNT_W'(1)) begin
                state_d = SB_IDLE;
            end else begin
                state_d.count = state_q.count - 1'b1;
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so all 31 slots see the same pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= SB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard for the ID stage: tracks in-flight writers per register
// and produces forwarding selects plus the load-use stall.
module reg_scoreboard
    import mycpu_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             issue_fire,
    input  logic [REG_W-1:0] issue_dest,
    input  logic             issue_load,
    input  logic             es_fire,
    input  logic             ms_fire,
    input  logic             ws_retire,
    input  logic [REG_W-1:0] ws_dest,
    input  logic             flush,
    input  logic [REG_W-1:0] id_raddr1,
    input  logic [REG_W-1:0] id_raddr2,
    input  logic             id_valid,
    output logic [1:0]       fwd_sel1,
    output logic [1:0]       fwd_sel2,
    output logic             load_stall,
    output logic             sb_overflow
);

    sb_state_t               entries [NUM_REGS];
    logic [NUM_REGS-1:1]     entry_ovf;
    logic                    sb_overflow_q;

    // r0 is hard-wired zero and is never a hazard source.
    assign entries[0] = SB_IDLE;

    generate
        for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
            sb_entry u_entry (
                .clk        (clk),
                .resetn     (resetn),
                .issue_hit  (issue_fire && (issue_dest == REG_W'(r))),
                .issue_load (issue_load),
                .retire_hit (ws_retire && (ws_dest == REG_W'(r))),
                .es_fire    (es_fire),
                .ms_fire    (ms_fire),
                .flush      (flush),
                .state      (entries[r]),
                .overflow   (entry_ovf[r])
            );
        end
    endgenerate

    // Sticky until reset; flush deliberately leaves it alone so the error survives recovery.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sb_overflow_q <= 1'b0;
        end else if (|entry_ovf) begin
            sb_overflow_q <= 1'b1;
        end
    end

    assign sb_overflow = sb_overflow_q;

    always_comb begin
        fwd_sel1   = FWD_RF;
        fwd_sel2   = FWD_RF;
        load_stall = 1'b0;
        if (id_raddr1 != '0) fwd_sel1 = fwd_of(entries[id_raddr1]);
        if (id_raddr2 != '0) fwd_sel2 = fwd_of(entries[id_raddr2]);
        if (id_valid) begin
            load_stall = ((id_raddr1 != '0) && load_hazard(entries[id_raddr1]))
                      || ((id_raddr2 != '0) && load_hazard(entries[id_raddr2]));
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard.
module tb_reg_scoreboard;

    logic       clk = 1'b0;
    logic       resetn;
    logic       issue_fire;
    logic [4:0] issue_dest;
    logic       issue_load;
    logic       es_fire;
    logic       ms_fire;
    logic       ws_retire;
    logic [4:0] ws_dest;
    logic       flush;
    logic [4:0] id_raddr1;
    logic [4:0] id_raddr2;
    logic       id_valid;
    logic [1:0] fwd_sel1;
    logic [1:0] fwd_sel2;
    logic       load_stall;
    logic       sb_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    reg_scoreboard dut (
        .clk         (clk),
        .resetn      (resetn),
        .issue_fire  (issue_fire),
        .issue_dest  (issue_dest),
        .issue_load  (issue_load),
        .es_fire     (es_fire),
        .ms_fire     (ms_fire),
        .ws_retire   (ws_retire),
        .ws_dest     (ws_dest),
        .flush       (flush),
        .id_raddr1   (id_raddr1),
        .id_raddr2   (id_raddr2),
        .id_valid    (id_valid),
        .fwd_sel1    (fwd_sel1),
        .fwd_sel2    (fwd_sel2),
        .load_stall  (load_stall),
        .sb_overflow (sb_overflow)
    );

    always #5 clk = ~clk;

    task automatic clear_pulses();
        issue_fire = 1'b0;
        issue_dest = 5'd0;
        issue_load = 1'b0;
        es_fire    = 1'b0;
        ms_fire    = 1'b0;
        ws_retire  = 1'b0;
        ws_dest    = 5'd0;
        flush      = 1'b0;
    endtask

    // Apply currently driven pulses at the next edge, then sample 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
        clear_pulses();
        #1;
    endtask

    task automatic do_issue(input logic [4:0] d, input logic ld);
        issue_fire = 1'b1;
        issue_dest = d;
        issue_load = ld;
        tick();
    endtask

    task automatic do_retire(input logic [4:0] d);
        ws_retire = 1'b1;
        ws_dest   = d;
        tick();
    endtask

    task automatic do_es();
        es_fire = 1'b1;
        tick();
    endtask

    task automatic do_ms();
        ms_fire = 1'b1;
        tick();
    endtask

    task automatic read_regs(input logic [4:0] a1, input logic [4:0] a2, input logic v);
        id_raddr1 = a1;
        id_raddr2 = a2;
        id_valid  = v;
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        clear_pulses();
        read_regs(5'd5, 5'd6, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (fwd_sel1 !== 2'b00) begin n_fail++; $display("FAIL reset_fwd1 got=%b exp=00", fwd_sel1); end
        n_checks++;
        if (fwd_sel2 !== 2'b00) begin n_fail++; $display("FAIL reset_fwd2 got=%b exp=00", fwd_sel2); end
        n_checks++;
        if (load_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", load_stall); end
        n_checks++;
        if (sb_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", sb_overflow); end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_fwd_exe();
        do_issue(5'd5, 1'b0);
        read_regs(5'd5, 5'd0, 1'b1);
        n_checks++;
        if (fwd_sel1 !== 2'b01) begin n_fail++; $display("FAIL add_fwd_exe got=%b exp=01", fwd_sel1); end
        n_checks++;
        if (load_stall !== 1'b0) begin n_fail++; $display("FAIL add_no_stall got=%b exp=0", load_stall); end
        do_es();
        n_checks++;
        if (fwd_sel1 !== 2'b10) begin n_fail++; $display("FAIL add_fwd_mem got=%b exp=10", fwd_sel1); end
        do_ms();
        n_checks++;
        if (fwd_sel1 !== 2'b11) begin n_fail++; $display("FAIL add_fwd_wb got=%b exp=11", fwd_sel1); end
        do_retire(5'd5);
        n_checks++;
        if (fwd_sel1 !== 2'b00) begin n_fail++; $display("FAIL add_retired got=%b exp=00", fwd_sel1); end
    endtask

    task automatic test_load_stall();
        do_issue(5'd6, 1'b1);
        read_regs(5'd0, 5'd6, 1'b1);
        n_checks++;
        if (load_stall !== 1'b1) begin n_fail++; $display("FAIL ld_stall got=%b exp=1", load_stall); end
        n_checks++;
        if (fwd_sel2 !== 2'b01) begin n_fail++; $display("FAIL ld_fwd_exe got=%b exp=01", fwd_sel2); end
        read_regs(5'd0, 5'd6, 1'b0);
        n_checks++;
        if (load_stall !== 1'b0) begin n_fail++; $display("FAIL ld_stall_novalid got=%b exp=0", load_stall); end
        read_regs(5'd0, 5'd6, 1'b1);
        do_es();
        n_checks++;
        if (fwd_sel2 !== 2'b10) begin n_fail++; $display("FAIL ld_fwd_mem got=%b exp=10", fwd_sel2); end
        n_checks++;
        if (load_stall !== 1'b0) begin n_fail++; $display("FAIL ld_stall_mem got=%b exp=0", load_stall); end
        do_ms();
        do_retire(5'd6);
        n_checks++;
        if (fwd_sel2 !== 2'b00) begin n_fail++; $display("FAIL ld_retired got=%b exp=00", fwd_sel2); end
    endtask

    task automatic test_back_to_back();
        read_regs(5'd7, 5'd0, 1'b1);
        do_issue(5'd7, 1'b0);
        es_fire = 1'b1;
        do_issue(5'd7, 1'b0);
        n_checks++;
        if (fwd_sel1 !== 2'b01) begin n_fail++; $display("FAIL b2b_young_exe got=%b exp=01", fwd_sel1); end
        do_ms();
        n_checks++;
        if (fwd_sel1 !== 2'b01) begin n_fail++; $display("FAIL b2b_ms_only got=%b exp=01", fwd_sel1); end
        do_retire(5'd7);
        n_checks++;
        if (fwd_sel1 !== 2'b01) begin n_fail++; $display("FAIL b2b_after_retire got=%b exp=01", fwd_sel1); end
        do_es();
        n_checks++;
        if (fwd_sel1 !== 2'b10) begin n_fail++; $display("FAIL b2b_young_mem got=%b exp=10", fwd_sel1); end
        do_ms();
        do_retire(5'd7);
        n_checks++;
        if (fwd_sel1 !== 2'b00) begin n_fail++; $display("FAIL b2b_count1 got=%b exp=00", fwd_sel1); end
    endtask

    task automatic test_issue_retire_same();
        read_regs(5'd8, 5'd0, 1'b1);
        do_issue(5'd8, 1'b0);
        do_es();
        n_checks++;
        if (fwd_sel1 !== 2'b10) begin n_fail++; $display("FAIL same_pre_mem got=%b exp=10", fwd_sel1); end
        ws_retire = 1'b1;
        ws_dest   = 5'd8;
        do_issue(5'd8, 1'b1);
        n_checks++;
        if (fwd_sel1 !== 2'b01) begin n_fail++; $display("FAIL same_stage_exe got=%b exp=01", fwd_sel1); end
        n_checks++;
        if (load_stall !== 1'b1) begin n_fail++; $display("FAIL same_load_bit got=%b exp=1", load_stall); end
        do_retire(5'd8);
        n_checks++;
        if (fwd_sel1 !== 2'b00) begin n_fail++; $display("FAIL same_count1 got=%b exp=00", fwd_sel1); end
    endtask

    task automatic test_overflow();
        read_regs(5'd9, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) do_issue(5'd9, 1'b0);
        n_checks++;
        if (sb_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_at3 got=%b exp=0", sb_overflow); end
        do_issue(5'd9, 1'b0);
        n_checks++;
        if (sb_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b exp=1", sb_overflow); end
        do_retire(5'd9);
        do_retire(5'd9);
        n_checks++;
        if (fwd_sel1 !== 2'b01) begin n_fail++; $display("FAIL ovf_count_left got=%b exp=01", fwd_sel1); end
        do_retire(5'd9);
        n_checks++;
        if (fwd_sel1 !== 2'b00) begin n_fail++; $display("FAIL ovf_count3 got=%b exp=00", fwd_sel1); end
        n_checks++;
        if (sb_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", sb_overflow); end
    endtask

    task automatic test_es_ms_same();
        read_regs(5'd10, 5'd11, 1'b0);
        do_issue(5'd10, 1'b0);
        es_fire = 1'b1;
        ms_fire = 1'b1;
        tick();
        n_checks++;
        if (fwd_sel1 !== 2'b10) begin n_fail++; $display("FAIL esms_no_double got=%b exp=10", fwd_sel1); end
        do_issue(5'd11, 1'b0);
        es_fire = 1'b1;
        ms_fire = 1'b1;
        tick();
        n_checks++;
        if (fwd_sel1 !== 2'b11) begin n_fail++; $display("FAIL esms_mem_to_wb got=%b exp=11", fwd_sel1); end
        n_checks++;
        if (fwd_sel2 !== 2'b10) begin n_fail++; $display("FAIL esms_exe_to_mem got=%b exp=10", fwd_sel2); end
    endtask

    task automatic test_flush();
        do_issue(5'd12, 1'b1);
        do_issue(5'd13, 1'b0);
        do_issue(5'd14, 1'b1);
        read_regs(5'd14, 5'd12, 1'b1);
        n_checks++;
        if (load_stall !== 1'b1) begin n_fail++; $display("FAIL flush_pre_stall got=%b exp=1", load_stall); end
        flush      = 1'b1;
        es_fire    = 1'b1;
        ws_retire  = 1'b1;
        ws_dest    = 5'd13;
        do_issue(5'd15, 1'b1);
        n_checks++;
        if (fwd_sel1 !== 2'b00 || fwd_sel2 !== 2'b00) begin
            n_fail++; $display("FAIL flush_fwd_a got=%b/%b exp=00/00", fwd_sel1, fwd_sel2);
        end
        n_checks++;
        if (load_stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got=%b exp=0", load_stall); end
        read_regs(5'd13, 5'd15, 1'b1);
        n_checks++;
        if (fwd_sel1 !== 2'b00 || fwd_sel2 !== 2'b00) begin
            n_fail++; $display("FAIL flush_fwd_b got=%b/%b exp=00/00", fwd_sel1, fwd_sel2);
        end
        read_regs(5'd10, 5'd11, 1'b1);
        n_checks++;
        if (fwd_sel1 !== 2'b00 || fwd_sel2 !== 2'b00) begin
            n_fail++; $display("FAIL flush_fwd_c got=%b/%b exp=00/00", fwd_sel1, fwd_sel2);
        end
        n_checks++;
        if (sb_overflow !== 1'b1) begin n_fail++; $display("FAIL flush_keeps_ovf got=%b exp=1", sb_overflow); end
    endtask

    task automatic test_r0();
        do_issue(5'd0, 1'b1);
        read_regs(5'd0, 5'd0, 1'b1);
        n_checks++;
        if (fwd_sel1 !== 2'b00 || fwd_sel2 !== 2'b00) begin
            n_fail++; $display("FAIL r0_fwd got=%b/%b exp=00/00", fwd_sel1, fwd_sel2);
        end
        n_checks++;
        if (load_stall !== 1'b0) begin n_fail++; $display("FAIL r0_stall got=%b exp=0", load_stall); end
    endtask

    task automatic test_reset_midstream();
        do_issue(5'd20, 1'b1);
        read_regs(5'd20, 5'd0, 1'b1);
        n_checks++;
        if (load_stall !== 1'b1) begin n_fail++; $display("FAIL rst_pre_stall got=%b exp=1", load_stall); end
        #1;
        resetn = 1'b0;
        #1;
        n_checks++;
        if (fwd_sel1 !== 2'b00) begin n_fail++; $display("FAIL rst_async_fwd got=%b exp=00", fwd_sel1); end
        n_checks++;
        if (load_stall !== 1'b0) begin n_fail++; $display("FAIL rst_async_stall got=%b exp=0", load_stall); end
        n_checks++;
        if (sb_overflow !== 1'b0) begin n_fail++; $display("FAIL rst_async_ovf got=%b exp=0", sb_overflow); end
        tick();
        resetn = 1'b1;
        tick();
        n_checks++;
        if (fwd_sel1 !== 2'b00) begin n_fail++; $display("FAIL rst_release_fwd got=%b exp=00", fwd_sel1); end
        do_issue(5'd20, 1'b0);
        n_checks++;
        if (fwd_sel1 !== 2'b01) begin n_fail++; $display("FAIL rst_first_issue got=%b exp=01", fwd_sel1); end
    endtask

    initial begin
        test_reset();
        test_fwd_exe();
        test_load_stall();
        test_back_to_back();
        test_issue_retire_same();
        test_overflow();
        test_es_ms_same();
        test_flush();
        test_r0();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
